// File: rtl/md_pkg.sv
// Shared encodings, FSM states and latencies for the multiply/divide sequencer.
// Build option MD_ITERDIV_EN selects the iterative divider over combinational / and %.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int ITERDIV_CYCLES  = 33;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_t;

    typedef enum logic [1:0] {
        DV_IDLE,
        DV_ITER,
        DV_FIX
    } div_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider: 32 magnitude iterations, then one sign-fixup cycle
// during which ready is high and quot/rem hold the final result.
module md_div_iter
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic        ready,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_t  dstate, dstate_n;
    logic [4:0]  step;
    logic [31:0] q_r, r_r, d_r, a_raw;
    logic        neg_q, neg_r, dz;
    logic [32:0] shifted, diff;

    assign shifted = {r_r, q_r[31]};
    assign diff    = shifted - {1'b0, d_r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dstate <= DV_IDLE;
        else       dstate <= dstate_n;
    end

    always_comb begin
        dstate_n = dstate;
        unique case (dstate)
            DV_IDLE: if (start) dstate_n = DV_ITER;
            DV_ITER: if (step == 5'd31) dstate_n = DV_FIX;
            DV_FIX:  dstate_n = DV_IDLE;
            default: dstate_n = DV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step  <= '0;
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            unique case (dstate)
                DV_IDLE: begin
                    if (start) begin
                        q_r   <= mag32(dividend, is_signed);
                        d_r   <= mag32(divisor, is_signed);
                        r_r   <= '0;
                        a_raw <= dividend;
                        neg_q <= is_signed & (dividend[31] ^ divisor[31]);
                        neg_r <= is_signed & dividend[31];
                        dz    <= (divisor == 32'd0);
                        step  <= '0;
                    end
                end
                DV_ITER: begin
                    step <= step + 5'd1;
                    q_r  <= {q_r[30:0], ~diff[32]};
                    r_r  <= diff[32] ? shifted[31:0] : diff[31:0];
                end
                default: ;
            endcase
        end
    end

    // Divide-by-zero bypasses the fixup so HI keeps the raw dividend
    assign ready = (dstate == DV_FIX);
    assign quot  = dz ? 32'hFFFF_FFFF : (neg_q ? (~q_r + 32'd1) : q_r);
    assign rem   = dz ? a_raw : (neg_r ? (~r_r + 32'd1) : r_r);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer behind EX: owns HI/LO, times MD ops, drives stall_md.
// Define MD_ITERDIV_EN to run DIV/DIVU on the iterative md_div_iter (33 cycles).
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hl_write,
    input  logic        hl_sel,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state, state_n;
    logic [5:0]  cnt, cnt_n, load_cnt;
    logic        accept, commit, wr_hl, fin;
    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] res_hi, res_lo, pend_hi, pend_lo, cmt_hi, cmt_lo;

    assign sgn   = ~op[0];
    assign ext_a = {{32{sgn & src_a[31]}}, src_a};
    assign ext_b = {{32{sgn & src_b[31]}}, src_b};
    assign prod  = ext_a * ext_b;

`ifdef MD_ITERDIV_EN
    localparam logic [5:0] DIV_LOAD = 6'(ITERDIV_CYCLES);

    logic        run_div, div_start, div_ready;
    logic [31:0] div_quot, div_rem;

    assign div_start = accept & op[1];

    md_div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (src_a),
        .divisor   (src_b),
        .is_signed (sgn),
        .ready     (div_ready),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       run_div <= 1'b0;
        else if (accept) run_div <= op[1];
    end

    assign res_hi = prod[63:32];
    assign res_lo = prod[31:0];
    assign fin    = run_div ? div_ready : (cnt == 6'd1);
    assign cmt_hi = run_div ? div_rem : pend_hi;
    assign cmt_lo = run_div ? div_quot : pend_lo;
`else
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    logic [31:0] div_q, div_r;

    always_comb begin
        div_q = 32'hFFFF_FFFF;
        div_r = src_a;
        if (src_b == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            div_r = src_a;
        end else if (sgn && src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
            div_q = 32'h8000_0000;
            div_r = 32'd0;
        end else if (sgn) begin
            div_q = $signed(src_a) / $signed(src_b);
            div_r = $signed(src_a) % $signed(src_b);
        end else begin
            div_q = src_a / src_b;
            div_r = src_a % src_b;
        end
    end

    assign res_hi = op[1] ? div_r : prod[63:32];
    assign res_lo = op[1] ? div_q : prod[31:0];
    assign fin    = (cnt == 6'd1);
    assign cmt_hi = pend_hi;
    assign cmt_lo = pend_lo;
`endif

    assign load_cnt = op[1] ? DIV_LOAD : 6'(MULT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        wr_hl   = 1'b0;
        busy    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    cnt_n   = load_cnt;
                    state_n = ST_RUN;
                end else if (hl_write) begin
                    wr_hl = 1'b1;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                cnt_n = cnt - 6'd1;
                if (fin) begin
                    commit  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stall must cover the start cycle itself, so it is not registered
    assign stall_md = md_use_d & (busy | start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (commit) begin
                hi <= cmt_hi;
                lo <= cmt_lo;
            end else if (wr_hl) begin
                if (hl_sel) hi <= src_a;
                else        lo <= src_a;
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: vector table, corner sequences, random ops
// against a 64-bit arithmetic reference model.
module tb_md_sched;
    import md_pkg::*;

`ifdef MD_ITERDIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 10;
`endif
    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        hl_write, hl_sel, md_use_d;
    logic        busy, stall_md, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_hi, cur_lo;

    md_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hl_write (hl_write),
        .hl_sel   (hl_sel),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall_md (stall_md),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic, no pipeline notion
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 0;
        l = 0;
        case (o)
            MD_MULT: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            MD_DIV: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int n;
        int lat;
        lat   = o[1] ? DIV_LAT : MUL_LAT;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        tick();
        chk({name, "_done_off"}, 32'(done), 32'd0);
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic [1:0]  o;
        int          n, pulses;

        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        src_a    = '0;
        src_b    = '0;
        hl_write = 1'b0;
        hl_sel   = 1'b0;
        md_use_d = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd7,         32'd2, 32'd1,         32'd3};
        vecs[4] = '{MD_DIV,   32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vecs[6] = '{MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[7] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[8] = '{MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
        vecs[9] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF};

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
                   $sformatf("vec%0d", i));

        // Stall window and MTHI during RUN
        md_use_d = 1'b1;
        start = 1'b1;
        op    = MD_MULT;
        src_a = 32'd3;
        src_b = 32'd4;
        #1;
        chk("stall_start", 32'(stall_md), 32'd1);
        tick();
        start    = 1'b0;
        hl_write = 1'b1;
        hl_sel   = 1'b1;
        src_a    = 32'hAAAA_5555;
        for (int i = 0; i < MUL_LAT; i++) begin
            chk($sformatf("stall_busy%0d", i), 32'(stall_md), 32'd1);
            chk($sformatf("hold_hi%0d", i), hi, cur_hi);
            tick();
        end
        hl_write = 1'b0;
        chk("stall_after", 32'(stall_md), 32'd0);
        chk("stall_busy_off", 32'(busy), 32'd0);
        chk("stall_hi", hi, 32'd0);
        chk("stall_lo", lo, 32'd12);
        md_use_d = 1'b0;
        tick();
        cur_hi = 32'd0;
        cur_lo = 32'd12;

        // MTHI / MTLO in IDLE
        hl_write = 1'b1;
        hl_sel   = 1'b1;
        src_a    = 32'hDEAD_BEEF;
        tick();
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_lo", lo, 32'd12);
        hl_sel = 1'b0;
        src_a  = 32'h0BAD_F00D;
        tick();
        hl_write = 1'b0;
        chk("mtlo_lo", lo, 32'h0BAD_F00D);
        chk("mtlo_hi", hi, 32'hDEAD_BEEF);

        // start beats hl_write in the same cycle
        hl_write = 1'b1;
        hl_sel   = 1'b0;
        start    = 1'b1;
        op       = MD_MULTU;
        src_a    = 32'd6;
        src_b    = 32'd7;
        tick();
        start    = 1'b0;
        hl_write = 1'b0;
        chk("sw_lo_hold", lo, 32'h0BAD_F00D);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk("sw_lat", 32'(n), 32'(MUL_LAT));
        chk("sw_lo", lo, 32'd42);
        chk("sw_hi", hi, 32'd0);
        tick();

        // Reset in the middle of a divide
        start = 1'b1;
        op    = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < DIV_LAT + 5; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("mid_rst_no_done", 32'(pulses), 32'd0);
        chk("mid_rst_lo_keep", lo, 32'd0);
        run_op(MD_MULT, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF7, "post_rst");

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hl_write = 1'b1;
                hl_sel   = 1'($urandom_range(0, 1));
                src_a    = $urandom;
                tick();
                hl_write = 1'b0;
                if (hl_sel) cur_hi = src_a;
                else        cur_lo = src_a;
                chk($sformatf("rnd%0d_mt_hi", i), hi, cur_hi);
                chk($sformatf("rnd%0d_mt_lo", i), lo, cur_lo);
            end
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3:       b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            model(o, a, b, eh, el);
            run_op(o, a, b, eh, el, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the multiply/divide resource behind the EX stage.
- Accepts one-cycle start pulses from ID/EX and owns the HI/LO registers.
- Times fixed-latency multiply and divide operations and drives the busy/stall handshake back to the hazard unit.
- Also services MTHI/MTLO writes and presents HI/LO to the EX-stage MFHI/MFLO path.

Parameters:
- MULT_CYCLES, 5: cycles busy is high after a MULT/MULTU start; legal 1..15.
- DIV_CYCLES, 10: cycles busy is high after a DIV/DIVU start; legal 1..63.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  E-stage start pulse for an MD operation
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- src_a  in  32  rs operand, forwarded E-stage value
- src_b  in  32  rt operand, forwarded E-stage value
- hl_write  in  1  MTHI/MTLO write strobe, E stage
- hl_sel  in  1  1 = HI, 0 = LO; used for hl_write
- md_use_d  in  1  instruction in D uses MD (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in flight
- stall_md  out  1  stall request for F/D, flush request for E
- done  out  1  one-cycle pulse on the edge HI/LO commit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, pending regs 0, hi=lo=0, busy=0, done=0. Reset mid-operation discards the pending result.
- States are IDLE and RUN.
- IDLE with start=1:
  - latch the result into pend_hi/pend_lo;
  - load cnt = MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1);
  - go to RUN.
- RUN:
  - busy=1; cnt decrements each edge.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, done pulses next cycle, state goes to IDLE.
  - busy is high for exactly N cycles, beginning the cycle after the start edge.
- stall_md = md_use_d & (busy | start). This is combinational and has no registered delay.
- start while RUN is ignored; the pipeline guarantees it cannot occur.
- hl_write:
  - IDLE and start=0: write src_a to HI (hl_sel=1) or LO (hl_sel=0) on the edge.
  - hl_write while RUN is ignored.
  - start together with hl_write in IDLE: start wins, write dropped.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits, {HI,LO}.
  - MULTU: unsigned 32x32 to 64 bits, {HI,LO}.
  - DIV: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU: unsigned division, LO=quotient, HI=remainder.
- Boundary results:
  - Divide by zero (src_b=0): LO=32'hFFFF_FFFF, HI=src_a.
  - Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- hi and lo change only on commit, on hl_write, or on reset. Reads during RUN return the old values; the hazard unit stalls MFHI/MFLO through stall_md.

Optional Feature:
- Macro: MD_ITERDIV_EN.
- Defined:
  - DIV/DIVU run on a radix-2 restoring divider, one quotient bit per cycle, operating on magnitudes with a sign fixup in the final cycle.
  - Division latency is 33 cycles (32 iterations + 1 fixup) and DIV_CYCLES is ignored.
  - Commit happens when the divider asserts its ready signal.
  - Boundary results are unchanged.
- Undefined:
  - Division uses combinational / and %, with DIV_CYCLES latency.
- Multiply timing is unaffected in both cases.

Decomposition:
- Package md_pkg holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum: ST_IDLE, ST_RUN;
  - default latencies: MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10, ITERDIV_CYCLES=33.
- Sub-module md_div_iter (start, dividend, divisor, is_signed, ready, quot, rem) is instantiated only under MD_ITERDIV_EN.

Test Plan:
1. MULT a=0xFFFF_FFFF, b=2 -> busy high 5 cycles, then done; HI=0xFFFF_FFFF, LO=0xFFFF_FFFE. MULTU with the same operands -> HI=1, LO=0xFFFF_FFFE.
2. DIV a=-7, b=2 -> after 10 busy cycles, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU a=7, b=2 -> LO=3, HI=1.
3. DIV b=0, a=0x1234 -> LO=0xFFFF_FFFF, HI=0x1234. DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
4. start MULT; md_use_d=1 for the following 6 cycles -> stall_md=1 in the start cycle and through all 5 busy cycles, 0 after commit. hl_write during RUN -> HI/LO unchanged.
5. IDLE: hl_write=1, hl_sel=1, a=0xDEAD_BEEF -> HI=0xDEAD_BEEF, LO unchanged. start together with hl_write -> only the MD result lands.
6. start DIV; assert reset at busy cycle 4 -> busy=0, HI=LO=0 immediately. No done pulse. A new MULT after reset completes normally.
